// File: rtl/weight_update_in.sv
// Input-to-hidden weight store for the XOR perceptron: accepts fp32 deltas, adds each one to
// the addressed weight through a pipelined fp32 adder, writes it back and exposes all weights.

module fp_adder #(
   parameter int LAT = 7
) (
   input  logic        iCLK,
   input  logic [31:0] iDATAA,
   input  logic [31:0] iDATAB,
   output logic [31:0] oRESULT
);
   logic        sa, sb, sr, up, sticky, tmp_s;
   logic        nan_a, nan_b, inf_a, inf_b;
   logic [9:0]  ea, eb, er, dexp, tmp_e;
   logic [26:0] ma, mb, mr, tmp_m;
   logic [27:0] acc;
   logic [24:0] rnd;
   logic [31:0] sum_d;
   logic [31:0] pipe_q [LAT];

   always_comb begin
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      sa     = iDATAA[31];
      sb     = iDATAB[31];
      ea     = (iDATAA[30:23] == 8'd0) ? 10'd1 : {2'b00, iDATAA[30:23]};
      eb     = (iDATAB[30:23] == 8'd0) ? 10'd1 : {2'b00, iDATAB[30:23]};
      ma     = {(iDATAA[30:23] != 8'd0), iDATAA[22:0], 3'b000};
      mb     = {(iDATAB[30:23] != 8'd0), iDATAB[22:0], 3'b000};
      tmp_s  = 1'b0;
      tmp_e  = '0;
      tmp_m  = '0;
      sticky = 1'b0;
      acc    = '0;
      mr     = '0;
      if ({eb, mb} > {ea, ma}) begin
         tmp_s = sa; tmp_e = ea; tmp_m = ma;
         sa    = sb; ea    = eb; ma    = mb;
         sb    = tmp_s; eb = tmp_e; mb = tmp_m;
      end
      // Align the smaller operand, folding shifted-out bits into a sticky bit.
      dexp = ea - eb;
      if (dexp > 10'd26) begin
         sticky = |mb;
         mb     = '0;
      end else begin
         sticky = |(mb & ((27'd1 << dexp) - 27'd1));
         mb     = mb >> dexp;
      end
      mb[0] = mb[0] | sticky;
      sr    = sa;
      er    = ea;
      if (sa == sb) begin
         acc = {1'b0, ma} + {1'b0, mb};
         if (acc[27]) begin
            mr = acc[27:1] | {26'd0, acc[0]};
            er = ea + 10'd1;
         end else begin
            mr = acc[26:0];
         end
      end else begin
         mr = ma - mb;
         for (int i = 0; i < 26; i++) begin
            if (!mr[26] && er > 10'd1) begin
               mr = mr << 1;
               er = er - 10'd1;
            end
         end
         if (mr == '0) sr = 1'b0;
      end
      up  = mr[2] & (mr[1] | mr[0] | mr[3]);
      rnd = {1'b0, mr[26:3]} + {24'd0, up};
      if (rnd[24]) begin
         rnd = rnd >> 1;
         er  = er + 10'd1;
      end
      nan_a = (iDATAA[30:23] == 8'hFF) && (iDATAA[22:0] != 23'd0);
      nan_b = (iDATAB[30:23] == 8'hFF) && (iDATAB[22:0] != 23'd0);
      inf_a = (iDATAA[30:23] == 8'hFF) && (iDATAA[22:0] == 23'd0);
      inf_b = (iDATAB[30:23] == 8'hFF) && (iDATAB[22:0] == 23'd0);
      if (nan_a || nan_b || (inf_a && inf_b && (iDATAA[31] != iDATAB[31])))
         sum_d = 32'h7FC0_0000;
      else if (inf_a)
         sum_d = {iDATAA[31], 8'hFF, 23'd0};
      else if (inf_b)
         sum_d = {iDATAB[31], 8'hFF, 23'd0};
      else if (er >= 10'd255)
         sum_d = {sr, 8'hFF, 23'd0};
      else
         sum_d = {sr, (rnd[23] ? er[7:0] : 8'd0), rnd[22:0]};
   end

   // NOTE: pipeline data carries no reset; the consumer decides when a result is valid.
   always_ff @(posedge iCLK) begin
      pipe_q[0] <= sum_d;
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
   end

   assign oRESULT = pipe_q[LAT-1];
endmodule

module weight_update_in #(
   parameter int N_W     = 6,
   parameter int IDX_W   = 3,
   parameter int ADD_LAT = 7
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iLOAD,
   input  logic [IDX_W-1:0]   iLOAD_IDX,
   input  logic [31:0]        iLOAD_VAL,
   input  logic               iDELTA_VALID,
   input  logic [IDX_W-1:0]   iDELTA_IDX,
   input  logic [31:0]        iDELTA,
   output logic               oREADY,
   output logic               oBUSY,
   output logic               oUPDATE_DONE,
   output logic               oIDX_ERR,
   output logic [15:0]        oUPD_CNT,
   output logic [N_W*32-1:0]  oWEIGHT
);
   localparam int               CNT_W = $clog2(ADD_LAT + 1);
   localparam logic [IDX_W:0]   N_W_L = (IDX_W+1)'(N_W);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_e;

   state_e           state_q;
   logic [31:0]      weight_q [N_W];
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      op_w_q, op_d_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q, err_q;
   logic [15:0]      upd_cnt_q;
   logic [31:0]      add_res;

   fp_adder #(.LAT(ADD_LAT)) u_add (
      .iCLK   (iCLK),
      .iDATAA (op_w_q),
      .iDATAB (op_d_q),
      .oRESULT(add_res)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= S_IDLE;
         for (int k = 0; k < N_W; k++) weight_q[k] <= '0;
         idx_q     <= '0;
         op_w_q    <= '0;
         op_d_q    <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         upd_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A load has priority; the offered delta stays pending upstream.
               if (iLOAD) begin
                  if ({1'b0, iLOAD_IDX} < N_W_L) weight_q[iLOAD_IDX] <= iLOAD_VAL;
               end else if (iDELTA_VALID) begin
                  if ({1'b0, iDELTA_IDX} < N_W_L) begin
                     idx_q   <= iDELTA_IDX;
                     op_w_q  <= weight_q[iDELTA_IDX];
                     op_d_q  <= iDELTA;
                     cnt_q   <= CNT_W'(ADD_LAT - 1);
                     state_q <= S_WAIT;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) state_q <= S_WRITE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            S_WRITE: begin
               weight_q[idx_q] <= add_res;
               done_q          <= 1'b1;
               upd_cnt_q       <= upd_cnt_q + 16'd1;
               state_q         <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      oWEIGHT = '0;
      for (int k = 0; k < N_W; k++) oWEIGHT[32*k +: 32] = weight_q[k];
   end

   assign oREADY       = (state_q == S_IDLE) && !iLOAD;
   assign oBUSY        = (state_q != S_IDLE);
   assign oUPDATE_DONE = done_q;
   assign oIDX_ERR     = err_q;
   assign oUPD_CNT     = upd_cnt_q;
endmodule

// File: doc/weight_update_in.md
Name: weight_update_in

Overview:
- Input-to-hidden weight store and updater for the XOR perceptron.
- Sits directly downstream of calculate_delta_in: accepts one delta (mu * error_h * x, IEEE-754 single) per handshake.
- Adds the delta to the addressed weight through the shared fp_adder IP and writes the sum back.
- Exposes all weights in parallel to the forward-pass hidden-layer neurons.

Parameters:
- N_W, 6, number of input-to-hidden weights (2 hidden neurons x (2 inputs + bias)).
- IDX_W, 3, index width; must satisfy 2^IDX_W >= N_W.
- ADD_LAT, 7, fp_adder pipeline latency in clocks (fixed by the IP configuration).

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST_N  in  1  synchronous active-low reset.
- iLOAD  in  1  write iLOAD_VAL to weight iLOAD_IDX (initialisation path).
- iLOAD_IDX  in  IDX_W  load target index.
- iLOAD_VAL  in  32  load value, fp32.
- iDELTA_VALID  in  1  delta offered this cycle.
- iDELTA_IDX  in  IDX_W  weight index the delta applies to.
- iDELTA  in  32  delta value, fp32.
- oREADY  out  1  block can accept a delta this cycle.
- oBUSY  out  1  an update is in flight.
- oUPDATE_DONE  out  1  one-cycle pulse when a weight write-back completes.
- oIDX_ERR  out  1  one-cycle pulse when an out-of-range index is rejected.
- oUPD_CNT  out  16  count of completed updates; wraps 0xFFFF -> 0x0000.
- oWEIGHT  out  N_W*32  all weights; weight k is on bits [32k+31:32k].

Behaviour:
- Clock and reset: one clock, iCLK. iRST_N is synchronous and active-low; it is sampled only on the iCLK rising edge.
- Reset values: all weights 0x00000000; FSM in IDLE; oBUSY=0; oUPDATE_DONE=0; oIDX_ERR=0; oUPD_CNT=0.
- Reset mid-operation: the in-flight update is abandoned and no write-back occurs. Any adder result emerging after reset is ignored.
- oREADY = (state==IDLE) && !iLOAD. It is combinational from state and iLOAD.
- FSM states:
  - IDLE: a delta is accepted when iDELTA_VALID && oREADY.
    - In-range index: latch the index, latch the delta, latch the current weight[idx] into the operand registers, then go to WAIT.
    - Index >= N_W: pulse oIDX_ERR next cycle, no state change, no write.
  - WAIT: operand registers drive fp_adder (dataa = weight operand, datab = delta). Operands are held stable.
    - A down-counter loaded with ADD_LAT-1 decrements each cycle.
    - At 0 go to WRITE.
  - WRITE: weight[idx] <= adder result; pulse oUPDATE_DONE; increment oUPD_CNT; return to IDLE.
- oBUSY = state != IDLE.
- Latency:
  - Acceptance edge to weight visible on oWEIGHT = ADD_LAT+1 clocks.
  - oUPDATE_DONE is asserted in the same cycle the new value first appears.
  - Next delta can be accepted the cycle after WRITE.
  - Throughput: one update per ADD_LAT+2 clocks.
- Arithmetic:
  - w_new = w + delta. The sign is already folded into the delta.
  - fp32 rounding, NaN and Inf handling are exactly those of fp_adder; no special-casing here.
- Load path:
  - iLOAD is honoured only in IDLE. weight[iLOAD_IDX] <= iLOAD_VAL on that edge.
  - An out-of-range load index is ignored with no error pulse.
  - iLOAD outside IDLE is ignored.
  - iLOAD in the same cycle as iDELTA_VALID: load wins; the delta is not accepted (oREADY=0) and the upstream must hold it.
- iDELTA_VALID while busy: not accepted. The upstream holds valid and data until oREADY.
- Weights not addressed by an update are never disturbed.

Test Plan:
- Reset then idle: all oWEIGHT=0, oUPD_CNT=0, oREADY=1, oBUSY=0; holds with no stimulus.
- Load w[2]=0x3F800000 (1.0), then delta 0x3E800000 (0.25) idx 2:
  - w[2]=0x3FA00000 (1.25) exactly ADD_LAT+1 clocks after acceptance.
  - oUPDATE_DONE pulses once; oUPD_CNT=1.
  - All other weights remain 0.
- Load w[0]=0x3E800000 (0.25), delta 0xBF000000 (-0.5) idx 0 -> w[0]=0xBE800000 (-0.25).
- Delta held valid for 3 consecutive indices, checking the busy handshake:
  - Each is accepted only when oREADY=1.
  - Three done pulses, spaced ADD_LAT+2 clocks apart.
  - oUPD_CNT=3 with no lost or duplicated updates.
- Simultaneous iLOAD and iDELTA_VALID in IDLE:
  - The load is applied and oREADY=0 that cycle.
  - The delta is accepted the next cycle and is applied on top of the loaded value.
- Delta idx 7 -> oIDX_ERR pulse, no weight change, oUPD_CNT unchanged.
- Reset asserted mid-WAIT -> all weights 0, no oUPDATE_DONE, IDLE next cycle.
